// File: rtl/op_mem_pkg.sv
// Shared address map for the memory-mapped peripheral windows (op_mem, ip_mem).
// Word indices are relative to the 64-byte window base; num_byte codes come from the LSU.
package op_mem_pkg;

    localparam logic [31:0] OP_BASE_ADDR = 32'h0000_7000;

    localparam logic [3:0] IDX_LEDR   = 4'd0;
    localparam logic [3:0] IDX_LEDG   = 4'd4;
    localparam logic [3:0] IDX_HEX_LO = 4'd8;
    localparam logic [3:0] IDX_HEX_HI = 4'd9;
    localparam logic [3:0] IDX_LCD    = 4'd12;

    typedef enum logic [3:0] {
        NB_BYTE = 4'b0001,
        NB_HALF = 4'b0011,
        NB_WORD = 4'b1111
    } num_byte_e;

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/op_byte_en.sv
// Store lane decode: byte enables, alignment legality and lane-shifted store data.
module op_byte_en
    import op_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  num_byte,
    input  logic [31:0] st_data,
    output logic [3:0]  byte_en,
    output logic        legal,
    output logic [31:0] wdata
);

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves an output unassigned (no latch).
        byte_en = 4'b0000;
        legal   = 1'b0;
        case (num_byte)
            NB_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                legal   = 1'b1;
            end
            NB_HALF: begin
                byte_en = 4'b0011 << addr_lo;
                legal   = ~addr_lo[0];
            end
            NB_WORD: begin
                byte_en = 4'b1111;
                legal   = (addr_lo == 2'b00);
            end
            default: ;
        endcase
    end

    assign wdata = st_data << {addr_lo, 3'b000};

endmodule

// File: rtl/op_mem.sv
// Output-peripheral register window: LED, 7-segment and LCD registers with
// byte-lane stores, registered read-back, LCD update strobe and sticky misalign flag.
module op_mem
    import op_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = OP_BASE_ADDR,
    parameter int unsigned LCD_PULSE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_num_byte,
    output logic [31:0] o_op_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    output logic        o_lcd_upd,
    output logic        o_misalign
);

    localparam int CW = $clog2(LCD_PULSE + 1);

    logic        hit;
    logic [3:0]  idx;
    logic [3:0]  byte_en;
    logic        legal;
    logic [31:0] wdata;
    logic        st_ok;
    logic        st_bad;
    logic [31:0] rd_word;

    logic [31:0] ledr_q, ledg_q, hex_lo_q, hex_hi_q, lcd_q, op_data_q;
    logic [CW-1:0] lcd_cnt_q;
    logic        misalign_q;

    assign hit    = (i_lsu_addr[31:6] == BASE_ADDR[31:6]);
    assign idx    = i_lsu_addr[5:2];
    assign st_ok  = hit & i_lsu_wren & legal;
    assign st_bad = hit & i_lsu_wren & ~legal;

    op_byte_en u_byte_en (
        .addr_lo  (i_lsu_addr[1:0]),
        .num_byte (i_num_byte),
        .st_data  (i_st_data),
        .byte_en  (byte_en),
        .legal    (legal),
        .wdata    (wdata)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: every peripheral register is a flop on the async reset; there is no RAM here to leave unreset.
        if (!i_rst) begin
            ledr_q   <= '0;
            ledg_q   <= '0;
            hex_lo_q <= '0;
            hex_hi_q <= '0;
            lcd_q    <= '0;
        end else if (st_ok) begin
            case (idx)
                IDX_LEDR:   ledr_q   <= merge_bytes(ledr_q,   wdata, byte_en);
                IDX_LEDG:   ledg_q   <= merge_bytes(ledg_q,   wdata, byte_en);
                IDX_HEX_LO: hex_lo_q <= merge_bytes(hex_lo_q, wdata, byte_en);
                IDX_HEX_HI: hex_hi_q <= merge_bytes(hex_hi_q, wdata, byte_en);
                IDX_LCD:    lcd_q    <= merge_bytes(lcd_q,    wdata, byte_en);
                default: ;
            endcase
        end
    end

    // Strobe counter reloads on every LCD store, so a store mid-pulse restarts it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lcd_cnt_q <= '0;
        end else if (st_ok && idx == IDX_LCD) begin
            lcd_cnt_q <= CW'(LCD_PULSE);
        end else if (lcd_cnt_q != '0) begin
            lcd_cnt_q <= lcd_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            misalign_q <= 1'b0;
        end else if (st_bad) begin
            misalign_q <= 1'b1;
        end
    end

    always_comb begin
        rd_word = '0;
        if (hit) begin
            case (idx)
                IDX_LEDR:   rd_word = ledr_q;
                IDX_LEDG:   rd_word = ledg_q;
                IDX_HEX_LO: rd_word = hex_lo_q;
                IDX_HEX_HI: rd_word = hex_hi_q;
                IDX_LCD:    rd_word = lcd_q;
                default:    rd_word = '0;
            endcase
        end
    end

    // Sampled from the pre-store registers, so a same-cycle store is not bypassed.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            op_data_q <= '0;
        end else begin
            op_data_q <= rd_word;
        end
    end

    assign o_op_data  = op_data_q;
    assign o_io_ledr  = ledr_q;
    assign o_io_ledg  = ledg_q;
    assign o_io_lcd   = lcd_q;
    assign o_lcd_upd  = (lcd_cnt_q != '0);
    assign o_misalign = misalign_q;

    assign o_io_hex0 = hex_lo_q[6:0];
    assign o_io_hex1 = hex_lo_q[14:8];
    assign o_io_hex2 = hex_lo_q[22:16];
    assign o_io_hex3 = hex_lo_q[30:24];
    assign o_io_hex4 = hex_hi_q[6:0];
    assign o_io_hex5 = hex_hi_q[14:8];
    assign o_io_hex6 = hex_hi_q[22:16];
    assign o_io_hex7 = hex_hi_q[30:24];

endmodule

// File: tb/tb_op_mem.sv
// Scoreboard bench for op_mem: a driver steps a window-level reference model and queues
// the expected post-edge outputs; a monitor pops and compares them after each rising edge.
module tb_op_mem;

    localparam logic [31:0] BASE  = 32'h0000_7000;
    localparam int          PULSE = 3;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_lsu_wren;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic [3:0]  i_num_byte;
    logic [31:0] o_op_data, o_io_ledr, o_io_ledg, o_io_lcd;
    logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
    logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
    logic        o_lcd_upd, o_misalign;
    logic [6:0]  hex_act [8];

    always #5 clk = ~clk;

    op_mem #(.BASE_ADDR(BASE), .LCD_PULSE(PULSE)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_lsu_wren (i_lsu_wren),
        .i_lsu_addr (i_lsu_addr),
        .i_st_data  (i_st_data),
        .i_num_byte (i_num_byte),
        .o_op_data  (o_op_data),
        .o_io_ledr  (o_io_ledr),
        .o_io_ledg  (o_io_ledg),
        .o_io_hex0  (o_io_hex0),
        .o_io_hex1  (o_io_hex1),
        .o_io_hex2  (o_io_hex2),
        .o_io_hex3  (o_io_hex3),
        .o_io_hex4  (o_io_hex4),
        .o_io_hex5  (o_io_hex5),
        .o_io_hex6  (o_io_hex6),
        .o_io_hex7  (o_io_hex7),
        .o_io_lcd   (o_io_lcd),
        .o_lcd_upd  (o_lcd_upd),
        .o_misalign (o_misalign)
    );

    assign hex_act[0] = o_io_hex0;
    assign hex_act[1] = o_io_hex1;
    assign hex_act[2] = o_io_hex2;
    assign hex_act[3] = o_io_hex3;
    assign hex_act[4] = o_io_hex4;
    assign hex_act[5] = o_io_hex5;
    assign hex_act[6] = o_io_hex6;
    assign hex_act[7] = o_io_hex7;

    typedef struct packed {
        logic [31:0]     op;
        logic [31:0]     ledr;
        logic [31:0]     ledg;
        logic [31:0]     lcd;
        logic [7:0][6:0] hex;
        logic            upd;
        logic            mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: the window as sixteen words plus the error flag and LCD store history.
    logic [31:0] words [16];
    logic        mis_m;
    int          step_n   = 0;
    int          last_lcd = -1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) words[i] = '0;
        mis_m    = 1'b0;
        last_lcd = -1000;
    endtask

    function automatic bit is_mapped(input int i);
        return (i == 0) || (i == 4) || (i == 8) || (i == 9) || (i == 12);
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the state after the next rising edge.
    task automatic step(input logic rst, input logic we, input logic [31:0] a,
                        input logic [3:0] nb, input logic [31:0] d);
        exp_t        e;
        bit          in_win;
        int          wi, lane, size;
        logic [31:0] rd;
        @(negedge clk);
        i_rst      = rst;
        i_lsu_wren = we;
        i_lsu_addr = a;
        i_num_byte = nb;
        i_st_data  = d;
        step_n++;
        rd = '0;
        if (!rst) begin
            model_reset();
        end else begin
            in_win = (a >= BASE) && (a < BASE + 32'd64);
            wi     = int'((a - BASE) >> 2) & 15;
            lane   = int'(a % 4);
            case (nb)
                4'b0001: size = 1;
                4'b0011: size = 2;
                4'b1111: size = 4;
                default: size = 0;
            endcase
            if (in_win && is_mapped(wi)) rd = words[wi];
            if (in_win && we) begin
                if (size != 0 && (lane % size) == 0) begin
                    if (is_mapped(wi)) begin
                        for (int b = 0; b < size; b++)
                            words[wi][8*(lane+b) +: 8] = d[8*b +: 8];
                        if (wi == 12) last_lcd = step_n;
                    end
                end else begin
                    mis_m = 1'b1;
                end
            end
        end
        e.op   = rd;
        e.ledr = words[0];
        e.ledg = words[4];
        e.lcd  = words[12];
        for (int n = 0; n < 8; n++) e.hex[n] = words[8 + n/4][8*(n%4) +: 7];
        e.upd  = (step_n - last_lcd) < PULSE;
        e.mis  = mis_m;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op"},   o_op_data, 32'h0);
        check({tag, "_ledr"}, o_io_ledr, 32'h0);
        check({tag, "_ledg"}, o_io_ledg, 32'h0);
        check({tag, "_lcd"},  o_io_lcd,  32'h0);
        check({tag, "_upd"},  32'(o_lcd_upd),  32'h0);
        check({tag, "_mis"},  32'(o_misalign), 32'h0);
        for (int n = 0; n < 8; n++) check($sformatf("%s_hex%0d", tag, n), 32'(hex_act[n]), 32'h0);
    endtask

    // Assert reset between edges and confirm outputs clear before the next rising edge.
    task automatic async_reset_check();
        @(negedge clk);
        #2;
        i_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
    endtask

    // Monitor: compares every queued expectation a little after the rising edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("op_data", o_op_data, e.op);
                check("ledr",    o_io_ledr, e.ledr);
                check("ledg",    o_io_ledg, e.ledg);
                check("lcd",     o_io_lcd,  e.lcd);
                check("lcd_upd", 32'(o_lcd_upd),  32'(e.upd));
                check("misalign",32'(o_misalign), 32'(e.mis));
                for (int n = 0; n < 8; n++)
                    check($sformatf("hex%0d", n), 32'(hex_act[n]), 32'(e.hex[n]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  nb;
        int          r;
        i_rst = 1'b0; i_lsu_wren = 1'b0; i_lsu_addr = '0; i_num_byte = '0; i_st_data = '0;
        model_reset();
        #3;
        check_all_zero("reset");

        // Stores while reset is held are discarded.
        step(1'b0, 1'b1, BASE,          4'b1111, 32'h1234_5678);
        step(1'b0, 1'b1, BASE + 32'h30, 4'b1111, 32'hCAFE_0000);

        // Word store to LEDR, then read it back; also a read in the same cycle as a store.
        step(1'b1, 1'b1, BASE,          4'b1111, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, BASE,          4'b1111, 32'h0);
        step(1'b1, 1'b1, BASE,          4'b1111, 32'h0BAD_F00D);
        step(1'b1, 1'b0, BASE,          4'b0001, 32'h0);

        // Byte to HEX2 leaves the other digits; bit 7 reads back.
        step(1'b1, 1'b1, BASE + 32'h20, 4'b1111, 32'h1122_3344);
        step(1'b1, 1'b1, BASE + 32'h22, 4'b0001, 32'h0000_007F);
        step(1'b1, 1'b1, BASE + 32'h27, 4'b0001, 32'h0000_00F1);
        step(1'b1, 1'b0, BASE + 32'h24, 4'b1111, 32'h0);
        step(1'b1, 1'b1, BASE + 32'h12, 4'b0011, 32'hFFFF_A5C3);

        // Outside the window and a reserved index: no effect, reads 0.
        step(1'b1, 1'b1, BASE + 32'h40, 4'b1111, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, BASE + 32'h04, 4'b1111, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, BASE + 32'h04, 4'b1111, 32'h0);

        // LCD strobe, then a restart in the second pulse cycle.
        step(1'b1, 1'b1, BASE + 32'h30, 4'b1111, 32'h4C43_4421);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, BASE + 32'h30, 4'b1111, 32'h0);
        step(1'b1, 1'b1, BASE + 32'h30, 4'b1111, 32'h0000_0001);
        step(1'b1, 1'b1, BASE + 32'h31, 4'b0001, 32'h0000_0002);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, BASE, 4'b1111, 32'h0);

        // Misaligned half and illegal code: flag sets and stays through legal stores.
        step(1'b1, 1'b1, BASE + 32'h11, 4'b0011, 32'h0000_FFFF);
        step(1'b1, 1'b1, BASE + 32'h10, 4'b1111, 32'h0000_0055);
        step(1'b1, 1'b1, BASE + 32'h10, 4'b0111, 32'h0000_0066);
        step(1'b1, 1'b0, BASE + 32'h10, 4'b1111, 32'h0);

        // Asynchronous reset mid-cycle, then a store on the first edge after release.
        step(1'b1, 1'b1, BASE,          4'b1111, 32'h0000_0001);
        async_reset_check();
        step(1'b0, 1'b1, BASE,          4'b1111, 32'h0000_0002);
        step(1'b1, 1'b1, BASE,          4'b1111, 32'h0000_0003);
        step(1'b1, 1'b0, BASE,          4'b1111, 32'h0);

        // Randomized traffic biased toward mapped words, with occasional resets.
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)
                a = BASE + 32'($urandom_range(0, 4)) * 32'd4 + 32'($urandom_range(0, 3));
            else if (r < 7)
                a = BASE + 32'($urandom_range(0, 63));
            else if (r == 7)
                a = BASE + 32'd64 + 32'($urandom_range(0, 255));
            else if (r == 8)
                a = BASE - 32'd1 - 32'($urandom_range(0, 255));
            else
                a = $urandom;
            if (r < 5 && a >= BASE + 32'd4) begin
                case ((a - BASE) >> 2)
                    32'd1: a = a + 32'd12;
                    32'd2: a = a + 32'd24;
                    32'd3: a = a + 32'd24;
                    32'd4: a = a + 32'd32;
                    default: ;
                endcase
            end
            case ($urandom_range(0, 4))
                0: nb = 4'b0001;
                1: nb = 4'b0011;
                2: nb = 4'b1111;
                3: nb = 4'b1111;
                default: nb = 4'($urandom);
            endcase
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), a, nb, $urandom);
        end

        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
